reg_file_param: RTL and testbench

//   Parametrised register file for the 16-bit processor datapath: two registered read ports
//   and one independent write port, so a read and a write happen in the same cycle.

---
 rtl/reg_file_param.sv | 162 ++++++++++++++++
 tb/tb_reg_file_param.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------
// reg_file_param
//   Parametrised register file for the 16-bit datapath. It has two registered
//   read ports and one independent write port, so a read and a write can
//   happen in the same cycle. A synchronous reset starts a sweep that clears
//   every entry to zero; ready rises once the sweep is done. Optional
//   write-to-read bypass and an optional hardwired-zero register 0.
//   All state updates on the FALLING edge of clk.
//
// Ports
//   clk       in   1       clock (falling edge active)
//   rst       in   1       synchronous reset, active-high
//   ready     out  1       1 = clear sweep done, accesses accepted
//   rd_en     in   1       read strobe for both ports
//   rd_addr1  in   ADDR_W  read address, port 1
//   rd_addr2  in   ADDR_W  read address, port 2
//   rd_data1  out  DATA_W  registered read data, port 1
//   rd_data2  out  DATA_W  registered read data, port 2
//   wr_en     in   1       write strobe
//   wr_addr   in   ADDR_W  write address
//   wr_data   in   DATA_W  write data
// ---------------------------------------------------------------------------
module reg_file_param #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  // Index width actually needed by the storage array; DEPTH <= 2**ADDR_W,
  // so IDX_W <= ADDR_W and the low address bits are enough once range-checked.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_PTR  = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t            state_reg;
  logic [ADDR_W:0]   clr_ptr_reg;
  logic              ready_reg;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              wr_ok;

  logic [ADDR_W-1:0] rd_addr_arr [2];

  // An address is live when it maps onto a real entry and is not the
  // hardwired-zero register. Reads of dead addresses return 0, writes drop.
  function automatic logic addr_live(input logic [ADDR_W-1:0] a);
    logic live;
    live = ({1'b0, a} < DEPTH_EXT);
    if (ZERO_REG != 0 && a == '0) begin
      live = 1'b0;
    end
    return live;
  endfunction

  assign wr_ok = wr_en && addr_live(wr_addr);

  assign rd_addr_arr[0] = rd_addr1;
  assign rd_addr_arr[1] = rd_addr2;

  // ---------------------------------------------------------------------
  // Control: clear sweep and ready flag
  // ---------------------------------------------------------------------
  always_ff @(negedge clk) begin
    if (rst) begin
      state_reg   <= CLEAR;
      clr_ptr_reg <= '0;
      ready_reg   <= 1'b0;
    end else if (state_reg == CLEAR) begin
      clr_ptr_reg <= clr_ptr_reg + 1'b1;
      // The edge that clears the last entry also opens the file for use.
      if (clr_ptr_reg == LAST_PTR) begin
        state_reg <= RUN;
        ready_reg <= 1'b1;
      end
    end
  end

  assign ready = ready_reg;

  // ---------------------------------------------------------------------
  // Single write port shared by the clear sweep and normal writes. The
  // reset edge itself leaves the contents untouched.
  // ---------------------------------------------------------------------
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (!rst) begin
      if (state_reg == CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_reg[IDX_W-1:0];
      end else if (wr_ok) begin
        mem_we    = 1'b1;
        mem_waddr = wr_addr[IDX_W-1:0];
        mem_wdata = wr_data;
      end
    end
  end

  always_ff @(negedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------
  // Read ports: identical logic per port, each with its own output register.
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      logic [DATA_W-1:0] value_next;
      logic [DATA_W-1:0] data_reg;

      always_comb begin
        value_next = '0;
        if (addr_live(rd_addr_arr[gi])) begin
          if (BYPASS != 0 && wr_en && wr_addr == rd_addr_arr[gi]) begin
            value_next = wr_data;
          end else begin
            value_next = mem[rd_addr_arr[gi][IDX_W-1:0]];
          end
        end
      end

      // Outputs are cleared by reset and then simply hold through the sweep.
      always_ff @(negedge clk) begin
        if (rst) begin
          data_reg <= '0;
        end else if (state_reg == RUN && rd_en) begin
          data_reg <= value_next;
        end
      end
    end
  endgenerate

  assign rd_data1 = g_rd[0].data_reg;
  assign rd_data2 = g_rd[1].data_reg;

endmodule

// File: tb/tb_reg_file_param.sv
// ---------------------------------------------------------------------------
// tb_reg_file_param
//   Drives two instances from the same stimulus: the default configuration
//   (DEPTH=32, BYPASS=1, ZERO_REG=0) and an alternate one (DEPTH=24,
//   BYPASS=0, ZERO_REG=1). Active edge is the falling edge; inputs change and
//   outputs are sampled 1 time unit after it.
// ---------------------------------------------------------------------------
module tb_reg_file_param;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;

  logic        m_ready;
  logic [15:0] m_rd1;
  logic [15:0] m_rd2;
  logic        z_ready;
  logic [15:0] z_rd1;
  logic [15:0] z_rd2;

  int checks;
  int failures;

  reg_file_param #(
    .DATA_W(16), .ADDR_W(5), .DEPTH(32), .BYPASS(1), .ZERO_REG(0)
  ) u_main (
    .clk(clk), .rst(rst), .ready(m_ready), .rd_en(rd_en),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(m_rd1), .rd_data2(m_rd2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  reg_file_param #(
    .DATA_W(16), .ADDR_W(5), .DEPTH(24), .BYPASS(0), .ZERO_REG(1)
  ) u_alt (
    .clk(clk), .rst(rst), .ready(z_ready), .rd_en(rd_en),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(z_rd1), .rd_data2(z_rd2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [15:0] m1;
    logic [15:0] m2;
    logic [15:0] z1;
    logic [15:0] z2;
  } vec_t;

  vec_t vecs [16];

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs a full sweep after rst has just dropped and checks ready per edge.
  task automatic sweep_check(input string tag);
    for (int e = 1; e <= 32; e++) begin
      step();
      check($sformatf("%s_main_ready_e%0d", tag, e), {15'd0, m_ready}, (e == 32) ? 16'd1 : 16'd0);
      check($sformatf("%s_alt_ready_e%0d", tag, e), {15'd0, z_ready}, (e >= 24) ? 16'd1 : 16'd0);
    end
    $display("sweep %s done: main ready=%0b alt ready=%0b", tag, m_ready, z_ready);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    rd_en    = 1'b0;
    rd_addr1 = '0;
    rd_addr2 = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;

    //                 wr_en  wr_addr wr_data   rd_en  a1     a2     main1     main2     alt1      alt2
    vecs[0]  = '{1'b1, 5'd3,  16'h50F5, 1'b0, 5'd8,  5'd5,  16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b1, 5'd8,  16'hAF0A, 1'b0, 5'd3,  5'd5,  16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd3,  5'd8,  16'h50F5, 16'hAF0A, 16'h50F5, 16'hAF0A};
    vecs[3]  = '{1'b1, 5'd5,  16'h1234, 1'b1, 5'd5,  5'd3,  16'h1234, 16'h50F5, 16'h0000, 16'h50F5};
    vecs[4]  = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd5,  5'd5,  16'h1234, 16'h1234, 16'h1234, 16'h1234};
    vecs[5]  = '{1'b1, 5'd0,  16'hFFFF, 1'b1, 5'd0,  5'd8,  16'hFFFF, 16'hAF0A, 16'h0000, 16'hAF0A};
    vecs[6]  = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd0,  5'd0,  16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
    vecs[7]  = '{1'b1, 5'd30, 16'hBEEF, 1'b1, 5'd30, 5'd3,  16'hBEEF, 16'h50F5, 16'h0000, 16'h50F5};
    vecs[8]  = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd30, 5'd30, 16'hBEEF, 16'hBEEF, 16'h0000, 16'h0000};
    vecs[9]  = '{1'b1, 5'd3,  16'h1111, 1'b0, 5'd8,  5'd5,  16'hBEEF, 16'hBEEF, 16'h0000, 16'h0000};
    vecs[10] = '{1'b1, 5'd8,  16'h2222, 1'b0, 5'd3,  5'd0,  16'hBEEF, 16'hBEEF, 16'h0000, 16'h0000};
    vecs[11] = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd3,  5'd8,  16'h1111, 16'h2222, 16'h1111, 16'h2222};
    vecs[12] = '{1'b1, 5'd23, 16'h7777, 1'b1, 5'd23, 5'd24, 16'h7777, 16'h0000, 16'h0000, 16'h0000};
    vecs[13] = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd23, 5'd31, 16'h7777, 16'h0000, 16'h7777, 16'h0000};
    vecs[14] = '{1'b1, 5'd3,  16'hAAAA, 1'b1, 5'd3,  5'd3,  16'hAAAA, 16'hAAAA, 16'h1111, 16'h1111};
    vecs[15] = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd3,  5'd3,  16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA};

    // Reset for two edges, then the clear sweep.
    step();
    step();
    check("reset_main_ready", {15'd0, m_ready}, 16'd0);
    check("reset_alt_ready", {15'd0, z_ready}, 16'd0);
    check("reset_main_rd1", m_rd1, 16'h0000);
    check("reset_alt_rd2", z_rd2, 16'h0000);
    rst = 1'b0;
    sweep_check("init");

    // Every address reads zero after the sweep.
    rd_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rd_addr1 = 5'(i);
      rd_addr2 = 5'(31 - i);
      step();
      check($sformatf("clr_main_rd1_a%0d", i), m_rd1, 16'h0000);
      check($sformatf("clr_main_rd2_a%0d", 31 - i), m_rd2, 16'h0000);
      check($sformatf("clr_alt_rd1_a%0d", i), z_rd1, 16'h0000);
    end
    $display("post-sweep read of all 32 addresses complete");

    // Table-driven RUN vectors, one edge each.
    for (int i = 0; i < 16; i++) begin
      wr_en    = vecs[i].wr_en;
      wr_addr  = vecs[i].wr_addr;
      wr_data  = vecs[i].wr_data;
      rd_en    = vecs[i].rd_en;
      rd_addr1 = vecs[i].a1;
      rd_addr2 = vecs[i].a2;
      step();
      $display("vec %0d: wr_en=%0b wa=%0d wd=%h rd_en=%0b a1=%0d a2=%0d -> main %h %h alt %h %h",
               i, wr_en, wr_addr, wr_data, rd_en, rd_addr1, rd_addr2, m_rd1, m_rd2, z_rd1, z_rd2);
      check($sformatf("vec%0d_main_rd1", i), m_rd1, vecs[i].m1);
      check($sformatf("vec%0d_main_rd2", i), m_rd2, vecs[i].m2);
      check($sformatf("vec%0d_alt_rd1", i), z_rd1, vecs[i].z1);
      check($sformatf("vec%0d_alt_rd2", i), z_rd2, vecs[i].z2);
    end
    wr_en = 1'b0;
    rd_en = 1'b0;

    // Reset, then accesses attempted during the sweep must be ignored.
    rst = 1'b1;
    step();
    check("rst2_main_rd1", m_rd1, 16'h0000);
    check("rst2_main_ready", {15'd0, m_ready}, 16'd0);
    rst      = 1'b0;
    wr_en    = 1'b1;
    wr_addr  = 5'd20;
    wr_data  = 16'h5555;
    rd_en    = 1'b1;
    rd_addr1 = 5'd3;
    rd_addr2 = 5'd20;
    for (int e = 1; e <= 9; e++) begin
      step();
      check($sformatf("mid_main_ready_e%0d", e), {15'd0, m_ready}, 16'd0);
      check($sformatf("mid_main_rd1_e%0d", e), m_rd1, 16'h0000);
      check($sformatf("mid_alt_rd2_e%0d", e), z_rd2, 16'h0000);
    end
    // Reset on edge 10 of the sweep restarts it from entry 0.
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst   = 1'b1;
    step();
    $display("mid-sweep reset applied");
    check("mid_rst_main_ready", {15'd0, m_ready}, 16'd0);
    rst = 1'b0;
    sweep_check("restart");

    // Earlier data must be gone, including the write attempted during CLEAR.
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd_addr1 = (i == 0) ? 5'd3 : (i == 1) ? 5'd20 : 5'd5;
      rd_addr2 = (i == 0) ? 5'd8 : (i == 1) ? 5'd30 : 5'd23;
      step();
      $display("post-restart read a1=%0d a2=%0d -> main %h %h alt %h %h",
               rd_addr1, rd_addr2, m_rd1, m_rd2, z_rd1, z_rd2);
      check($sformatf("restart_main_rd1_a%0d", rd_addr1), m_rd1, 16'h0000);
      check($sformatf("restart_main_rd2_a%0d", rd_addr2), m_rd2, 16'h0000);
      check($sformatf("restart_alt_rd1_a%0d", rd_addr1), z_rd1, 16'h0000);
      check($sformatf("restart_alt_rd2_a%0d", rd_addr2), z_rd2, 16'h0000);
    end

    // Hold: load known values, then change memory and addresses with rd_en=0.
    wr_en    = 1'b1;
    wr_addr  = 5'd7;
    wr_data  = 16'hC3C3;
    rd_en    = 1'b0;
    step();
    wr_en    = 1'b0;
    rd_en    = 1'b1;
    rd_addr1 = 5'd7;
    rd_addr2 = 5'd7;
    step();
    check("hold_load_main_rd1", m_rd1, 16'hC3C3);
    check("hold_load_alt_rd2", z_rd2, 16'hC3C3);
    rd_en    = 1'b0;
    wr_en    = 1'b1;
    wr_data  = 16'h3C3C;
    rd_addr1 = 5'd1;
    rd_addr2 = 5'd2;
    step();
    step();
    $display("hold after rd_en=0: main %h %h alt %h %h", m_rd1, m_rd2, z_rd1, z_rd2);
    check("hold_main_rd1", m_rd1, 16'hC3C3);
    check("hold_main_rd2", m_rd2, 16'hC3C3);
    check("hold_alt_rd1", z_rd1, 16'hC3C3);
    check("hold_alt_rd2", z_rd2, 16'hC3C3);
    wr_en    = 1'b0;
    rd_en    = 1'b1;
    rd_addr1 = 5'd7;
    step();
    check("hold_then_read_main_rd1", m_rd1, 16'h3C3C);
    check("hold_then_read_alt_rd1", z_rd1, 16'h3C3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
